// File: rtl/vec_mem_arbiter.sv
// Two-port (pipeline/host) arbiter for the single-port vector data memory.
// Optional grant statistics outputs enabled by defining VEC_ARB_STATS_EN.
module vec_mem_arbiter #(
  parameter int unsigned vecSize      = 4,
  parameter int unsigned registerSize = 16,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             pipe_req,
  input  logic                             pipe_we,
  input  logic [registerSize-1:0]          pipe_addr,
  input  logic [vecSize*registerSize-1:0]  pipe_wdata,
  output logic                             pipe_ack,
  output logic [vecSize*registerSize-1:0]  pipe_rdata,
  input  logic                             host_req,
  input  logic                             host_we,
  input  logic [registerSize-1:0]          host_addr,
  input  logic [vecSize*registerSize-1:0]  host_wdata,
  output logic                             host_ack,
  output logic [vecSize*registerSize-1:0]  host_rdata,
  output logic                             mem_en,
  output logic                             mem_we,
  output logic [registerSize-1:0]          mem_addr,
  output logic [vecSize*registerSize-1:0]  mem_wdata,
  input  logic [vecSize*registerSize-1:0]  mem_rdata,
  output logic                             busy,
  output logic                             grant_host
`ifdef VEC_ARB_STATS_EN
  ,
  output logic [31:0]                      pipe_grants,
  output logic [31:0]                      host_grants,
  output logic [15:0]                      starve_events
`endif
);

  localparam int unsigned VW = vecSize * registerSize;
  localparam int unsigned LW = $clog2(MEM_LAT + 1);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [LW-1:0] LAT_INIT   = LW'(MEM_LAT);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_e;

  state_e                  state_q, state_d;
  logic [LW-1:0]           lat_q, lat_d;
  logic [SW-1:0]           starve_q, starve_d;
  logic                    host_sel_q, host_sel_d;
  logic                    we_q, we_d;
  logic [registerSize-1:0] addr_q, addr_d;
  logic [VW-1:0]           wdata_q, wdata_d;
  logic [VW-1:0]           pipe_rdata_q, pipe_rdata_d;
  logic [VW-1:0]           host_rdata_q, host_rdata_d;
  logic                    take_host;
`ifdef VEC_ARB_STATS_EN
  logic                    forced_q, forced_d;
  logic [31:0]             pg_q, pg_d, hg_q, hg_d;
  logic [15:0]             se_q, se_d;

  assign pipe_grants   = pg_q;
  assign host_grants   = hg_q;
  assign starve_events = se_q;
`endif

  assign pipe_rdata = pipe_rdata_q;
  assign host_rdata = host_rdata_q;
  assign grant_host = host_sel_q;
  assign busy       = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      lat_q        <= '0;
      starve_q     <= '0;
      host_sel_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      pipe_rdata_q <= '0;
      host_rdata_q <= '0;
`ifdef VEC_ARB_STATS_EN
      forced_q     <= 1'b0;
      pg_q         <= '0;
      hg_q         <= '0;
      se_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      starve_q     <= starve_d;
      host_sel_q   <= host_sel_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      pipe_rdata_q <= pipe_rdata_d;
      host_rdata_q <= host_rdata_d;
`ifdef VEC_ARB_STATS_EN
      forced_q     <= forced_d;
      pg_q         <= pg_d;
      hg_q         <= hg_d;
      se_q         <= se_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    starve_d     = starve_q;
    host_sel_d   = host_sel_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    pipe_rdata_d = pipe_rdata_q;
    host_rdata_d = host_rdata_q;
    take_host    = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    pipe_ack     = 1'b0;
    host_ack     = 1'b0;
`ifdef VEC_ARB_STATS_EN
    forced_d     = forced_q;
    pg_d         = pg_q;
    hg_d         = hg_q;
    se_d         = se_q;
`endif

    case (state_q)
      IDLE: begin
        if (pipe_req || host_req) begin
          // Pipe has priority until the host has watched STARVE_LIMIT pipe grants in a row.
          take_host  = host_req && (!pipe_req || (starve_q == STARVE_MAX));
          host_sel_d = take_host;
          we_d       = take_host ? host_we    : pipe_we;
          addr_d     = take_host ? host_addr  : pipe_addr;
          wdata_d    = take_host ? host_wdata : pipe_wdata;
          if (take_host || !host_req) begin
            starve_d = '0;
          end else if (starve_q != STARVE_MAX) begin
            starve_d = starve_q + SW'(1);
          end
`ifdef VEC_ARB_STATS_EN
          forced_d = take_host && pipe_req;
`endif
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        lat_d     = LAT_INIT;
        state_d   = WAIT;
`ifdef VEC_ARB_STATS_EN
        if (host_sel_q) begin
          if (hg_q != '1) hg_d = hg_q + 32'd1;
          if (forced_q && (se_q != '1)) se_d = se_q + 16'd1;
        end else if (pg_q != '1) begin
          pg_d = pg_q + 32'd1;
        end
`endif
      end
      WAIT: begin
        if (lat_q == LW'(1)) begin
          if (host_sel_q) host_rdata_d = mem_rdata;
          else            pipe_rdata_d = mem_rdata;
          state_d = ACK;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      ACK: begin
        pipe_ack = !host_sel_q;
        host_ack = host_sel_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// Self-checking bench for vec_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model; a MEM_LAT=3 instance checks latency.
module tb_vec_mem_arbiter;

  localparam int MEM_LAT = 1;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset, mem_clr;
  logic        pipe_req, pipe_we, host_req, host_we;
  logic [15:0] pipe_addr, host_addr;
  logic [63:0] pipe_wdata, host_wdata;
  logic        pipe_ack, host_ack, mem_en, mem_we, busy, grant_host;
  logic [63:0] pipe_rdata, host_rdata, mem_wdata, mem_rdata;
  logic [15:0] mem_addr;

  logic        d3_req;
  logic [15:0] d3_addr;
  logic [63:0] d3_wdata;
  logic        d3_ack, d3_hack, d3_en, d3_we, d3_busy, d3_grant;
  logic [63:0] d3_rdata, d3_hrdata, d3_mwdata, d3_mrdata;
  logic [15:0] d3_maddr;

`ifdef VEC_ARB_STATS_EN
  logic [31:0] pipe_grants, host_grants, d3_pg, d3_hg;
  logic [15:0] starve_events, d3_se;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vec_mem_arbiter #(.vecSize(4), .registerSize(16), .MEM_LAT(MEM_LAT), .STARVE_LIMIT(STARVE_LIMIT)) u_dut (
    .clk(clk), .reset(reset),
    .pipe_req(pipe_req), .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_ack(pipe_ack), .pipe_rdata(pipe_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .grant_host(grant_host)
`ifdef VEC_ARB_STATS_EN
    , .pipe_grants(pipe_grants), .host_grants(host_grants), .starve_events(starve_events)
`endif
  );

  vec_mem_arbiter #(.vecSize(4), .registerSize(16), .MEM_LAT(3), .STARVE_LIMIT(STARVE_LIMIT)) u_dut3 (
    .clk(clk), .reset(reset),
    .pipe_req(d3_req), .pipe_we(1'b0), .pipe_addr(d3_addr), .pipe_wdata(d3_wdata),
    .pipe_ack(d3_ack), .pipe_rdata(d3_rdata),
    .host_req(1'b0), .host_we(1'b0), .host_addr(16'h0), .host_wdata(64'h0),
    .host_ack(d3_hack), .host_rdata(d3_hrdata),
    .mem_en(d3_en), .mem_we(d3_we), .mem_addr(d3_maddr), .mem_wdata(d3_mwdata),
    .mem_rdata(d3_mrdata), .busy(d3_busy), .grant_host(d3_grant)
`ifdef VEC_ARB_STATS_EN
    , .pipe_grants(d3_pg), .host_grants(d3_hg), .starve_events(d3_se)
`endif
  );

  // Environment memory: read data appears MEM_LAT cycles after the strobe, zero otherwise.
  logic [63:0] env_mem [0:255];
  logic [63:0] rd_pipe [0:MEM_LAT-1];
  always @(posedge clk) begin
    for (int i = MEM_LAT - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
    rd_pipe[0] <= mem_en ? env_mem[mem_addr[7:0]] : 64'h0;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 64'h0;
    end else if (mem_en && mem_we) begin
      env_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = rd_pipe[MEM_LAT-1];

  function automatic logic [63:0] pat(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1234};
  endfunction

  logic [63:0] d3_pipe [0:2];
  always @(posedge clk) begin
    d3_pipe[2] <= d3_pipe[1];
    d3_pipe[1] <= d3_pipe[0];
    d3_pipe[0] <= d3_en ? pat(d3_maddr) : 64'h0;
  end
  assign d3_mrdata = d3_pipe[2];

  // Transaction-level reference model
  logic [63:0] ref_mem [0:255];
  logic [63:0] exp_prd, exp_hrd;
  int m_starve, m_pg, m_hg, m_se;

  task automatic model_reset();
    m_starve = 0; m_pg = 0; m_hg = 0; m_se = 0;
    exp_prd = 64'h0; exp_hrd = 64'h0;
  endtask

  // Returns 1 when the host wins this arbitration.
  function automatic bit model_arb(input bit p, input bit h);
    bit hw;
    hw = h && (!p || m_starve == STARVE_LIMIT);
    if (hw) begin
      m_hg++;
      if (p) m_se++;
      m_starve = 0;
    end else begin
      m_pg++;
      m_starve = h ? ((m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT) : 0;
    end
    return hw;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; pipe_req = 1'b0; host_req = 1'b0; d3_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic do_access(input bit p, input bit h,
                           input bit pwe, input logic [15:0] pa, input logic [63:0] pd,
                           input bit hwe, input logic [15:0] ha, input logic [63:0] hd);
    bit hw, swe;
    logic [15:0] sa;
    logic [63:0] sd, old;
    int k;
    @(negedge clk);
    pipe_req = p; pipe_we = pwe; pipe_addr = pa; pipe_wdata = pd;
    host_req = h; host_we = hwe; host_addr = ha; host_wdata = hd;
    hw  = model_arb(p, h);
    swe = hw ? hwe : pwe;
    sa  = hw ? ha : pa;
    sd  = hw ? hd : pd;
    @(posedge clk); #1;
    check("issue_mem_en", mem_en, 1);
    check("issue_mem_we", mem_we, swe);
    check("issue_mem_addr", mem_addr, sa);
    if (swe) check("issue_mem_wdata", mem_wdata, sd);
    check("issue_grant_host", grant_host, hw);
    check("issue_busy", busy, 1);
    old = ref_mem[sa[7:0]];
    if (swe) ref_mem[sa[7:0]] = sd;
    if (hw) exp_hrd = old; else exp_prd = old;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
      if (!(pipe_ack || host_ack)) check("wait_mem_en", mem_en, 0);
    end while (!(pipe_ack || host_ack) && k < 20);
    check("ack_latency", k, 1 + MEM_LAT);
    check("pipe_ack", pipe_ack, !hw);
    check("host_ack", host_ack, hw);
    check("pipe_rdata", pipe_rdata, exp_prd);
    check("host_rdata", host_rdata, exp_hrd);
    @(negedge clk);
    pipe_req = 1'b0; host_req = 1'b0;
    @(posedge clk); #1;
    check("ack_pulse_pipe", pipe_ack, 0);
    check("ack_pulse_host", host_ack, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic hold_both(input int n, input logic [15:0] pa, input logic [15:0] ha);
    bit hw;
    int k;
    @(negedge clk);
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = pa;
    host_req = 1'b1; host_we = 1'b0; host_addr = ha;
    for (int i = 0; i < n; i++) begin
      k = 0;
      do begin
        @(posedge clk); #1;
        k++;
      end while (!(pipe_ack || host_ack) && k < 30);
      hw = model_arb(1'b1, 1'b1);
      if (hw) exp_hrd = ref_mem[ha[7:0]]; else exp_prd = ref_mem[pa[7:0]];
      check("hold_latency", k, (i == 0) ? 2 + MEM_LAT : 3 + MEM_LAT);
      check("hold_host_ack", host_ack, hw);
      check("hold_pipe_ack", pipe_ack, !hw);
      check("hold_grant_host", grant_host, hw);
      check(hw ? "hold_host_rdata" : "hold_pipe_rdata", hw ? host_rdata : pipe_rdata,
            hw ? exp_hrd : exp_prd);
    end
    @(negedge clk);
    pipe_req = 1'b0; host_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic read3(input logic [15:0] a);
    int k;
    @(negedge clk);
    d3_req = 1'b1; d3_addr = a; d3_wdata = 64'h0;
    @(posedge clk); #1;
    check("lat3_mem_en", d3_en, 1);
    check("lat3_mem_addr", d3_maddr, a);
    check("lat3_mem_we", d3_we, 0);
    check("lat3_mem_wdata", d3_mwdata, 64'h0);
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!d3_ack && k < 20);
    check("lat3_ack_latency", k, 4);
    check("lat3_rdata", d3_rdata, pat(a));
    check("lat3_host_ack", d3_hack, 0);
    check("lat3_grant_host", d3_grant, 0);
    @(negedge clk);
    d3_req = 1'b0;
    @(posedge clk); #1;
    check("lat3_busy", d3_busy, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] ra, rb;
    bit rp, rh;
    reset = 1'b1; mem_clr = 1'b1;
    pipe_req = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    d3_req = 1'b0; d3_addr = '0; d3_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 64'h0;
    model_reset();

    // Reset held with no requests
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_mem_en", mem_en, 0);
      check("rst_busy", busy, 0);
    end
    check("rst_pipe_ack", pipe_ack, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_pipe_rdata", pipe_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_mem_fields", {mem_we, mem_addr, mem_wdata[46:0]}, 0);
    check("rst_grant_host", grant_host, 0);
    @(negedge clk);
    reset = 1'b0; mem_clr = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      check("idle_mem_en", mem_en, 0);
    end

    // Pipe write/read, then host write/read at another address
    do_access(1, 0, 1, 16'd4, 64'hDEADBEEFBEEFDEAD, 0, 16'd0, 64'h0);
    do_access(1, 0, 0, 16'd4, 64'h0, 0, 16'd0, 64'h0);
    do_access(0, 1, 0, 16'd0, 64'h0, 1, 16'd8, 64'hCAFEBABECAFEBABE);
    do_access(0, 1, 0, 16'd0, 64'h0, 0, 16'd8, 64'h0);
    check("pipe_rdata_kept", pipe_rdata, 64'hDEADBEEFBEEFDEAD);
    check("host_rdata_read", host_rdata, 64'hCAFEBABECAFEBABE);

    // Starvation bound with both requests held
    do_reset();
    hold_both(10, 16'd4, 16'd8);
`ifdef VEC_ARB_STATS_EN
    check("stats_pipe_grants", pipe_grants, m_pg);
    check("stats_host_grants", host_grants, m_hg);
    check("stats_starve_events", starve_events, m_se);
`endif

    // Reset during WAIT of a pipe read
    @(negedge clk);
    pipe_req = 1'b1; pipe_we = 1'b0; pipe_addr = 16'd4;
    @(posedge clk); #1;
    check("midrst_issue", mem_en, 1);
    @(posedge clk); #1;
    check("midrst_wait_busy", busy, 1);
    @(negedge clk);
    reset = 1'b1; pipe_req = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("midrst_busy", busy, 0);
    check("midrst_pipe_ack", pipe_ack, 0);
    check("midrst_pipe_rdata", pipe_rdata, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_no_ack", pipe_ack, 0);
    do_access(0, 1, 0, 16'd0, 64'h0, 0, 16'd8, 64'h0);

    // Randomized traffic against the model
    repeat (40) begin
      rp = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      if (!rp && !rh) rp = 1'b1;
      ra = 16'($urandom_range(0, 15)) | (16'($urandom) & 16'hFF00);
      rb = 16'($urandom_range(0, 15)) | (16'($urandom) & 16'hFF00);
      do_access(rp, rh, 1'($urandom_range(0, 1)), ra, {$urandom, $urandom},
                1'($urandom_range(0, 1)), rb, {$urandom, $urandom});
    end

    // Longer memory latency instance
    read3(16'h0012);
    read3(16'hA5F0);
    read3(16'($urandom));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vec_mem_arbiter.md
Name: vec_mem_arbiter

Overview:
Arbitrates the single-port vector data memory between two requesters: the pipeline port (writeback-stage loads/stores) and the host port (image loader/debug). Each access is sequenced through a fixed-latency issue/wait/ack FSM. The pipeline has priority, bounded by a starvation limit that guarantees host progress. Sits between stage_writeback and the data memory instance.

Parameters:
vecSize, 4, lanes per vector word
registerSize, 16, bits per lane; also address width
MEM_LAT, 1, memory read latency in cycles after mem_en (must be >=1)
STARVE_LIMIT, 4, consecutive pipe grants allowed while host waits (must be >=1)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
pipe_req  in  1  pipeline access request, held until pipe_ack
pipe_we  in  1  1=write, 0=read
pipe_addr  in  registerSize  word address
pipe_wdata  in  vecSize x registerSize  write vector
pipe_ack  out  1  one-cycle completion pulse
pipe_rdata  out  vecSize x registerSize  read vector, valid with pipe_ack
host_req, host_we, host_addr, host_wdata  in  same widths as pipe_*  host request
host_ack  out  1  one-cycle completion pulse
host_rdata  out  vecSize x registerSize  read vector, valid with host_ack
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable, qualified by mem_en
mem_addr  out  registerSize  memory address
mem_wdata  out  vecSize x registerSize  memory write data
mem_rdata  in  vecSize x registerSize  memory read data, valid MEM_LAT cycles after mem_en
busy  out  1  high in any state except IDLE
grant_host  out  1  1 when the current/last grant is host

Behaviour:
- Reset: state=IDLE; all outputs 0 (acks, rdata, mem_*, busy, grant_host); starvation counter=0.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE: when any req is high, pick a winner and latch its we/addr/wdata; go to ISSUE. No req: stay.
- Arbitration: only pipe -> pipe; only host -> host; both -> pipe unless starve_cnt==STARVE_LIMIT, then host.
- starve_cnt: +1 when pipe wins while host_req=1; cleared when host wins, or at arbitration when host_req=0. Saturates at STARVE_LIMIT.
- ISSUE (1 cycle): mem_en=1; mem_we/addr/wdata from latched request. Go to WAIT with lat_cnt=MEM_LAT.
- WAIT: lat_cnt decrements each cycle. On the cycle lat_cnt==1, capture mem_rdata into the winner's rdata register, then go to ACK. mem_en=0 throughout.
- ACK (1 cycle): winner's ack=1; then IDLE. The loser's rdata is unchanged.
- Timing: req first sampled in IDLE at cycle t -> mem_en at t+1 -> ack at t+2+MEM_LAT (MEM_LAT=1: ack at t+3). Reads and writes use identical timing. On a write, rdata is still loaded with mem_rdata; requesters ignore rdata on writes.
- Requester may deassert req in the ack cycle. A req still high at the next IDLE is a new request.
- A req change during ISSUE/WAIT/ACK is ignored: the latched request is used.
- rdata registers hold their value until the next completed read/write of that port.
- Reset mid-operation: return to IDLE next cycle; no ack issued. A memory write already strobed is not undone.
- Addresses pass unmodified. No bounds check.

Optional Feature:
Macro VEC_ARB_STATS_EN.
- Defined: adds outputs pipe_grants and host_grants (32-bit, saturating) and starve_events (16-bit, count of host wins forced by STARVE_LIMIT). All clear on reset and increment in the ISSUE cycle.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
1. Reset, hold 3 cycles, no reqs -> all outputs 0, busy=0, mem_en never high.
2. Pipe write addr=4, wdata=64'hDEADBEEFBEEFDEAD at cycle t -> mem_en=1, mem_we=1, mem_addr=4 at t+1; pipe_ack at t+3. Then pipe read addr=4 -> pipe_rdata=64'hDEADBEEFBEEFDEAD with pipe_ack, host_ack never high.
3. Host read addr=8 after host write 64'hCAFEBABECAFEBABE -> host_rdata=64'hCAFEBABECAFEBABE; pipe_rdata unchanged from scenario 2.
4. pipe_req and host_req both held continuously, STARVE_LIMIT=4 -> grant sequence pipe,pipe,pipe,pipe,host,pipe...; grant_host=1 only on the 5th access.
5. reset asserted during WAIT of a pipe read -> next cycle state IDLE, busy=0, no pipe_ack; a fresh host read then completes normally.
6. MEM_LAT=3 build, pipe read -> mem_en at t+1, ack at t+5. With VEC_ARB_STATS_EN, after scenario 4's 10 accesses -> pipe_grants=8, host_grants=2, starve_events=2.
